// File: rtl/pool_pkg.sv
// pool_pkg: shared point-count constants and feeder state encoding for the pooling path
package pool_pkg;

    localparam int POOL_POINTS = 49;
    localparam int POOL_IDX_W  = 6;

    typedef enum logic [1:0] {
        FEED_IDLE,
        FEED_STREAM,
        FEED_WAIT_DONE
    } feed_state_t;

endpackage

// File: rtl/pool_feeder_ram.sv
// pool_feeder_ram: two-bank simple dual-port RAM, one write port, one registered read port
module pool_feeder_ram
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [POOL_IDX_W:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [POOL_IDX_W:0]   rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Address is {bank, idx}, so the array spans the full index range of both banks.
    logic [DATA_WIDTH-1:0] mem [0:2**(POOL_IDX_W+1)-1];

    // Storage write; contents are never reset.
    always_ff @(posedge clock)
        if (wr_en) mem[wr_addr] <= wr_data;

    // One-cycle read; the output register clears so out_data starts at zero.
    always_ff @(posedge clock or posedge reset)
        if (reset) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];

endmodule

// File: rtl/pool_feeder.sv
// pool_feeder: ping-pong tile buffer replaying full tiles as gap-free bursts to the pooler
module pool_feeder
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int POINTS     = POOL_POINTS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  pool_done,
    output logic                  busy,
    output logic                  proto_err
);

    localparam logic [POOL_IDX_W-1:0] LAST = POOL_IDX_W'(POINTS - 1);

    feed_state_t           state;
    logic                  wr_bank, rd_bank;
    logic [POOL_IDX_W-1:0] wr_idx, rd_idx;
    logic [1:0]            full, full_set, full_clr;
    logic                  wr_fire, wr_last, release_bank;

    assign in_ready     = !full[wr_bank];
    assign wr_fire      = in_valid && in_ready;
    assign wr_last      = wr_idx == LAST;
    assign release_bank = state == FEED_WAIT_DONE && pool_done;
    assign full_set     = {2{wr_fire && wr_last}} & (wr_bank ? 2'b10 : 2'b01);
    assign full_clr     = {2{release_bank}} & (rd_bank ? 2'b10 : 2'b01);
    assign busy         = |full || state != FEED_IDLE;

    // Write pointer walks through a bank and flips to the other one after the last point.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (wr_fire) begin
            wr_idx <= wr_last ? '0 : wr_idx + POOL_IDX_W'(1);
            if (wr_last) wr_bank <= ~wr_bank;
        end

    // Bank full flags; set and clear always target different banks, so both apply.
    always_ff @(posedge clock or posedge reset)
        if (reset) full <= 2'b00;
        else full <= (full | full_set) & ~full_clr;

    // Read FSM: wait for a full bank, stream it, then hold until the pooler releases it.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state     <= FEED_IDLE;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            out_valid <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            out_valid <= state == FEED_STREAM;
            proto_err <= proto_err | (pool_done && state != FEED_WAIT_DONE);
            case (state)
                FEED_IDLE:
                    if (full[rd_bank]) begin
                        state  <= FEED_STREAM;
                        rd_idx <= '0;
                    end
                FEED_STREAM: begin
                    rd_idx <= rd_idx + POOL_IDX_W'(1);
                    if (rd_idx == LAST) state <= FEED_WAIT_DONE;
                end
                FEED_WAIT_DONE:
                    if (pool_done) begin
                        rd_bank <= ~rd_bank;
                        state   <= FEED_IDLE;
                    end
                default: state <= FEED_IDLE;
            endcase
        end

    pool_feeder_ram #(.DATA_WIDTH(DATA_WIDTH)) ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_fire),
        .wr_addr ({wr_bank, wr_idx}),
        .wr_data (in_data),
        .rd_en   (state == FEED_STREAM),
        .rd_addr ({rd_bank, rd_idx}),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_pool_feeder.sv
// tb_pool_feeder: two feeder instances (49 and 4 points) checked every cycle against a tile-schedule model
module tb_pool_feeder;

    logic        clock = 1'b0;
    logic        rst       [2] = '{1'b1, 1'b1};
    logic [31:0] in_data   [2] = '{32'd0, 32'd0};
    logic        in_valid  [2] = '{1'b0, 1'b0};
    logic        in_ready  [2];
    logic [31:0] out_data  [2];
    logic        out_valid [2];
    logic        pool_done [2] = '{1'b0, 1'b0};
    logic        busy      [2];
    logic        proto_err [2];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h expected=%h at %0t", nm, g, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input int g, input logic [31:0] v);
        int   n;
        logic ok;
        n = 0;
        in_valid[g] = 1'b1;
        in_data[g]  = v;
        do begin
            ok = in_ready[g];
            @(posedge clock);
            #1;
            n++;
        end while (!ok && n < 2000);
        in_valid[g] = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout[%0d] got=stalled expected=accept value %h", g, v);
        end
    endtask

    task automatic pulse_done(input int g);
        pool_done[g] = 1'b1;
        cycles(1);
        pool_done[g] = 1'b0;
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int P = (g == 0) ? 49 : 4;

        pool_feeder #(.DATA_WIDTH(32), .POINTS(P)) dut (
            .clock     (clock),
            .reset     (rst[g]),
            .in_data   (in_data[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .out_data  (out_data[g]),
            .out_valid (out_valid[g]),
            .pool_done (pool_done[g]),
            .busy      (busy[g]),
            .proto_err (proto_err[g])
        );

        // Model: completed tiles queued in order; the front tile becomes available at edge
        // 'avail', bursts at edges avail+2..avail+P+1, and may be released from avail+P+2.
        logic [31:0] dq[$];
        logic [31:0] part[$];
        int          held  = 0;
        int          avail = -1;
        int          cyc   = 0;
        bit          perr  = 1'b0;

        always @(posedge clock or posedge rst[g]) begin
            if (rst[g]) begin
                dq.delete();
                part.delete();
                held  = 0;
                avail = -1;
                cyc   = 0;
                perr  = 1'b0;
            end else begin
                bit rdy;
                cyc++;
                rdy = held < 2;
                if (pool_done[g]) begin
                    if (held > 0 && cyc >= avail + P + 2) begin
                        repeat (P) void'(dq.pop_front());
                        held--;
                        avail = (held > 0) ? cyc : -1;
                    end else perr = 1'b1;
                end
                if (in_valid[g] && rdy) begin
                    part.push_back(in_data[g]);
                    if (part.size() == P) begin
                        foreach (part[i]) dq.push_back(part[i]);
                        part.delete();
                        held++;
                        if (held == 1) avail = cyc;
                    end
                end
            end
        end

        always @(negedge clock) begin
            bit ev;
            ev = held > 0 && cyc >= avail + 2 && cyc <= avail + P + 1;
            chk("out_valid", g, out_valid[g], ev);
            if (ev) chk("out_data", g, out_data[g], dq[cyc - avail - 2]);
            chk("in_ready", g, in_ready[g], held < 2);
            chk("busy", g, busy[g], held > 0);
            chk("proto_err", g, proto_err[g], perr);
        end
    end

    task automatic run0();
        int seen, n;
        cycles(2);
        rst[0] = 1'b0;
        chk("rst_out_valid", 0, out_valid[0], 0);
        chk("rst_out_data", 0, out_data[0], 0);
        chk("rst_busy", 0, busy[0], 0);
        chk("rst_in_ready", 0, in_ready[0], 1);
        chk("rst_proto_err", 0, proto_err[0], 0);
        for (int v = 1; v <= 49; v++) wr(0, v);
        chk("lat_k", 0, out_valid[0], 0);
        cycles(1);
        chk("lat_k1", 0, out_valid[0], 0);
        cycles(1);
        chk("lat_k2_valid", 0, out_valid[0], 1);
        chk("lat_k2_data", 0, out_data[0], 1);
        for (int v = 50; v <= 98; v++) wr(0, v);
        chk("both_full_ready", 0, in_ready[0], 0);
        chk("both_full_busy", 0, busy[0], 1);
        in_valid[0] = 1'b1;
        in_data[0]  = 99;
        cycles(50);
        chk("stall_ready", 0, in_ready[0], 0);
        pulse_done(0);
        chk("release_ready", 0, in_ready[0], 1);
        wr(0, 99);
        wr(0, 100);
        chk("burst2_valid", 0, out_valid[0], 1);
        chk("burst2_data", 0, out_data[0], 50);
        for (int v = 101; v <= 120; v++) wr(0, v);
        pool_done[0] = 1'b1;
        wr(0, 121);
        pool_done[0] = 1'b0;
        chk("proto_err_set", 0, proto_err[0], 1);
        for (int v = 122; v <= 147; v++) wr(0, v);
        cycles(10);
        chk("proto_err_sticky", 0, proto_err[0], 1);
        pulse_done(0);
        seen = 0;
        n = 0;
        while (seen < 19 && n < 200) begin
            cycles(1);
            if (out_valid[0]) seen++;
            n++;
        end
        chk("burst3_seen", 0, seen, 19);
        cycles(1);
        rst[0] = 1'b1;
        #1;
        chk("midrst_valid", 0, out_valid[0], 0);
        chk("midrst_busy", 0, busy[0], 0);
        chk("midrst_ready", 0, in_ready[0], 1);
        cycles(2);
        rst[0] = 1'b0;
        for (int i = 0; i < 49; i++) wr(0, 32'hA5A5_0000 + i);
        cycles(55);
        pulse_done(0);
        cycles(3);
        chk("end_busy", 0, busy[0], 0);
    endtask

    task automatic run1();
        cycles(2);
        rst[1] = 1'b0;
        fork
            begin
                for (int i = 0; i < 160; i++) begin
                    if ($urandom_range(0, 1) == 1) cycles($urandom_range(1, 3));
                    wr(1, $urandom);
                end
            end
            begin
                for (int t = 0; t < 40; t++) begin
                    int cnt, n;
                    cnt = 0;
                    n = 0;
                    while (cnt < 4 && n < 2000) begin
                        cycles(1);
                        if (out_valid[1]) cnt++;
                        n++;
                    end
                    chk("p4_burst_len", 1, cnt, 4);
                    cycles(4);
                    pulse_done(1);
                end
            end
        join
        cycles(3);
        chk("p4_proto_err", 1, proto_err[1], 0);
        chk("p4_busy", 1, busy[1], 0);
    endtask

    initial begin
        fork
            run0();
            run1();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1);
    end

endmodule
